sap1_program_loader: RTL and testbench

Writer side of the SAP-1 instruction path. Accepts one-hot mnemonic commands (LDA/ADD/SUB/OUT/HLT) with a 4-bit operand. Encodes each command into the 8-bit SAP-1 instruction word {opcode, operand} and writes the words sequentially into the 16x8 program RAM over a write/ack handshake. Holds the CPU in clear for the whole load, and releases it once a HLT has been written.

---
 rtl/sap1_pkg.sv | 31 +++
 rtl/sap1_program_loader_if.sv | 45 ++++
 rtl/sap1_instr_encoder.sv | 34 +++
 rtl/sap1_program_loader.sv | 142 ++++++++++++++
 tb/tb_sap1_program_loader.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions used by the program loader and the instruction decoder.
// Keeping the opcode values in one place means the writer and reader of the
// program RAM always agree on the instruction encoding.
//   ADDR_W         : program RAM address width (16 words)
//   OP_*           : 4-bit opcodes placed in the upper nibble of each word
//   loader_state_e : program loader session states
//   make_word      : packs {opcode, operand} into one 8-bit instruction word
package sap1_pkg;

    localparam int ADDR_W = 4;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_WRITE,
        ST_DONE,
        ST_ERROR
    } loader_state_e;

    function automatic logic [7:0] make_word(input logic [3:0] opcode,
                                             input logic [3:0] operand);
        return {opcode, operand};
    endfunction

endpackage

// File: rtl/sap1_program_loader_if.sv
// Bundles the program loader's command input, RAM write port and status lines.
//   start                  : one-cycle pulse that opens a load session
//   cmd_valid / cmd_ready  : command handshake
//   cmd_lda..cmd_hlt       : one-hot mnemonic select
//   cmd_operand            : 4-bit address operand
//   mem_addr/data/we/ack   : program RAM write handshake
//   low_cpu_clr            : active-low CPU clear
//   load_done / load_err   : session outcome levels
//   words_written          : number of words committed in this session
// The loader uses the master modport; the command source and RAM side use slave.
interface sap1_program_loader_if #(parameter int ADDR_W = sap1_pkg::ADDR_W);

    logic              start;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_lda;
    logic              cmd_add;
    logic              cmd_sub;
    logic              cmd_out;
    logic              cmd_hlt;
    logic [3:0]        cmd_operand;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic              mem_we;
    logic              mem_ack;
    logic              low_cpu_clr;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   words_written;

    modport master (
        input  start, cmd_valid, cmd_lda, cmd_add, cmd_sub, cmd_out, cmd_hlt,
               cmd_operand, mem_ack,
        output cmd_ready, mem_addr, mem_data, mem_we, low_cpu_clr,
               load_done, load_err, words_written
    );

    modport slave (
        output start, cmd_valid, cmd_lda, cmd_add, cmd_sub, cmd_out, cmd_hlt,
               cmd_operand, mem_ack,
        input  cmd_ready, mem_addr, mem_data, mem_we, low_cpu_clr,
               load_done, load_err, words_written
    );

endinterface

// File: rtl/sap1_instr_encoder.sv
// Combinational SAP-1 instruction encoder; the exact inverse of the decoder.
//   sel_lda..sel_hlt : one-hot mnemonic select
//   operand          : 4-bit address operand (dropped for OUT and HLT)
//   word             : encoded {opcode, operand} instruction word
//   onehot_ok        : 1 only when exactly one select is set
module sap1_instr_encoder
    import sap1_pkg::*;
(
    input  logic       sel_lda,
    input  logic       sel_add,
    input  logic       sel_sub,
    input  logic       sel_out,
    input  logic       sel_hlt,
    input  logic [3:0] operand,
    output logic [7:0] word,
    output logic       onehot_ok
);

    // Any pattern other than a single set bit falls to the default and is
    // reported as invalid with a zero word.
    always_comb begin
        word      = 8'h00;
        onehot_ok = 1'b0;
        case ({sel_lda, sel_add, sel_sub, sel_out, sel_hlt})
            5'b10000: begin word = make_word(OP_LDA, operand); onehot_ok = 1'b1; end
            5'b01000: begin word = make_word(OP_ADD, operand); onehot_ok = 1'b1; end
            5'b00100: begin word = make_word(OP_SUB, operand); onehot_ok = 1'b1; end
            5'b00010: begin word = make_word(OP_OUT, 4'h0);    onehot_ok = 1'b1; end
            5'b00001: begin word = make_word(OP_HLT, 4'h0);    onehot_ok = 1'b1; end
            default:  begin word = 8'h00;                      onehot_ok = 1'b0; end
        endcase
    end

endmodule

// File: rtl/sap1_program_loader.sv
// Writer side of the SAP-1 instruction path. Encodes one-hot mnemonic commands
// into instruction words and writes them sequentially into the 16x8 program RAM,
// holding the CPU in clear until a HLT has been written.
//   clk : system clock, rising edge
//   clr : asynchronous active-high reset
//   bus : command, RAM write and status signals (master side)
module sap1_program_loader #(
    parameter int ADDR_W = sap1_pkg::ADDR_W
) (
    input  logic                  clk,
    input  logic                  clr,
    sap1_program_loader_if.master bus
);

    import sap1_pkg::*;

    loader_state_e     state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_data_q, mem_data_d;
    logic              mem_we_q, mem_we_d;
    logic              low_cpu_clr_q, low_cpu_clr_d;
    logic              load_done_q, load_done_d;
    logic              load_err_q, load_err_d;
    logic [ADDR_W:0]   words_written_q, words_written_d;

    logic [7:0]        enc_word;
    logic              enc_ok;

    sap1_instr_encoder u_encoder (
        .sel_lda   (bus.cmd_lda),
        .sel_add   (bus.cmd_add),
        .sel_sub   (bus.cmd_sub),
        .sel_out   (bus.cmd_out),
        .sel_hlt   (bus.cmd_hlt),
        .operand   (bus.cmd_operand),
        .word      (enc_word),
        .onehot_ok (enc_ok)
    );

    // Next-state and next-output logic. Every output is registered, so each
    // transition sets the output values that belong to the state being entered.
    always_comb begin
        state_d         = state_q;
        cmd_ready_d     = cmd_ready_q;
        mem_addr_d      = mem_addr_q;
        mem_data_d      = mem_data_q;
        mem_we_d        = mem_we_q;
        low_cpu_clr_d   = low_cpu_clr_q;
        load_done_d     = load_done_q;
        load_err_d      = load_err_q;
        words_written_d = words_written_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (bus.start) begin
                    state_d         = ST_ACCEPT;
                    cmd_ready_d     = 1'b1;
                    mem_addr_d      = '0;
                    words_written_d = '0;
                    load_done_d     = 1'b0;
                    load_err_d      = 1'b0;
                    low_cpu_clr_d   = 1'b0;
                end
            end

            ST_ACCEPT: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    if (enc_ok) begin
                        mem_data_d = enc_word;
                        mem_we_d   = 1'b1;
                        state_d    = ST_WRITE;
                    end else begin
                        load_err_d = 1'b1;
                        state_d    = ST_ERROR;
                    end
                end
            end

            ST_WRITE: begin
                // Address and data stay frozen until the RAM acknowledges.
                // A full RAM without HLT is an overflow; the address never wraps.
                if (bus.mem_ack) begin
                    mem_we_d        = 1'b0;
                    words_written_d = words_written_q + {{ADDR_W{1'b0}}, 1'b1};
                    if (mem_data_q[7:4] == OP_HLT) begin
                        load_done_d   = 1'b1;
                        low_cpu_clr_d = 1'b1;
                        state_d       = ST_DONE;
                    end else if (mem_addr_q == {ADDR_W{1'b1}}) begin
                        load_err_d = 1'b1;
                        state_d    = ST_ERROR;
                    end else begin
                        mem_addr_d  = mem_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                        cmd_ready_d = 1'b1;
                        state_d     = ST_ACCEPT;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Session state and registered outputs; reset abandons any write in flight.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q         <= ST_IDLE;
            cmd_ready_q     <= 1'b0;
            mem_addr_q      <= '0;
            mem_data_q      <= 8'h00;
            mem_we_q        <= 1'b0;
            low_cpu_clr_q   <= 1'b1;
            load_done_q     <= 1'b0;
            load_err_q      <= 1'b0;
            words_written_q <= '0;
        end else begin
            state_q         <= state_d;
            cmd_ready_q     <= cmd_ready_d;
            mem_addr_q      <= mem_addr_d;
            mem_data_q      <= mem_data_d;
            mem_we_q        <= mem_we_d;
            low_cpu_clr_q   <= low_cpu_clr_d;
            load_done_q     <= load_done_d;
            load_err_q      <= load_err_d;
            words_written_q <= words_written_d;
        end
    end

    assign bus.cmd_ready     = cmd_ready_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_data      = mem_data_q;
    assign bus.mem_we        = mem_we_q;
    assign bus.low_cpu_clr   = low_cpu_clr_q;
    assign bus.load_done     = load_done_q;
    assign bus.load_err      = load_err_q;
    assign bus.words_written = words_written_q;

endmodule

// File: tb/tb_sap1_program_loader.sv
// Testbench for sap1_program_loader. A session-level reference model tracks
// what the loader must present on every cycle, a RAM responder acknowledges
// writes with programmable delay, and directed plus randomized programs are
// driven through the command handshake.
module tb_sap1_program_loader;

    localparam logic [4:0] S_LDA = 5'b10000;
    localparam logic [4:0] S_ADD = 5'b01000;
    localparam logic [4:0] S_SUB = 5'b00100;
    localparam logic [4:0] S_OUT = 5'b00010;
    localparam logic [4:0] S_HLT = 5'b00001;

    logic clk = 1'b0;
    logic clr = 1'b0;

    sap1_program_loader_if #(.ADDR_W(4)) bus ();

    sap1_program_loader #(.ADDR_W(4)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks_total  = 0;
    int checks_passed = 0;

    // Reference model state: what each loader output must be after an edge.
    logic       m_ready   = 1'b0;
    logic       m_we      = 1'b0;
    logic       m_done    = 1'b0;
    logic       m_err     = 1'b0;
    logic       m_cpu_clr = 1'b1;
    logic [3:0] m_addr    = 4'h0;
    logic [7:0] m_data    = 8'h00;
    int         m_count   = 0;
    logic [4:0] m_sel;

    // Every completed RAM write as {addr, data}.
    logic [11:0] write_log[$];

    int ack_delay = 0;
    bit ack_noise = 1'b0;
    int we_cycles = 0;

    function automatic logic [7:0] expect_word(input logic [4:0] sel, input logic [3:0] operand);
        case (sel)
            S_LDA:   return {4'h0, operand};
            S_ADD:   return {4'h1, operand};
            S_SUB:   return {4'h2, operand};
            S_OUT:   return 8'hE0;
            S_HLT:   return 8'hF0;
            default: return 8'h00;
        endcase
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected) checks_passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    endtask

    // Reference model, advanced on the same edges the loader sees.
    initial forever begin
        @(posedge clk or posedge clr);
        if (clr) begin
            m_ready = 1'b0; m_we = 1'b0; m_done = 1'b0; m_err = 1'b0;
            m_cpu_clr = 1'b1; m_addr = 4'h0; m_data = 8'h00; m_count = 0;
        end else begin
            if (bus.mem_we && bus.mem_ack) write_log.push_back({bus.mem_addr, bus.mem_data});
            if (m_we) begin
                if (bus.mem_ack) begin
                    m_we = 1'b0;
                    m_count++;
                    if (m_data[7:4] == 4'hF) begin
                        m_done = 1'b1;
                        m_cpu_clr = 1'b1;
                    end else if (m_addr == 4'd15) begin
                        m_err = 1'b1;
                    end else begin
                        m_addr = m_addr + 4'd1;
                        m_ready = 1'b1;
                    end
                end
            end else if (m_ready) begin
                if (bus.cmd_valid) begin
                    m_ready = 1'b0;
                    m_sel = {bus.cmd_lda, bus.cmd_add, bus.cmd_sub, bus.cmd_out, bus.cmd_hlt};
                    if ($countones(m_sel) == 1) begin
                        m_data = expect_word(m_sel, bus.cmd_operand);
                        m_we = 1'b1;
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end else if (bus.start) begin
                m_addr = 4'h0; m_count = 0; m_done = 1'b0; m_err = 1'b0;
                m_cpu_clr = 1'b0; m_ready = 1'b1;
            end
        end
    end

    // Compare every loader output against the model on every falling edge.
    initial forever begin
        @(negedge clk);
        check_output("cmd_ready",     32'(bus.cmd_ready),     32'(m_ready));
        check_output("mem_we",        32'(bus.mem_we),        32'(m_we));
        check_output("mem_addr",      32'(bus.mem_addr),      32'(m_addr));
        check_output("mem_data",      32'(bus.mem_data),      32'(m_data));
        check_output("load_done",     32'(bus.load_done),     32'(m_done));
        check_output("load_err",      32'(bus.load_err),      32'(m_err));
        check_output("low_cpu_clr",   32'(bus.low_cpu_clr),   32'(m_cpu_clr));
        check_output("words_written", 32'(bus.words_written), 32'(m_count));
    end

    // RAM responder: acknowledges after ack_delay cycles of mem_we, and may
    // toggle mem_ack randomly while no write is pending.
    initial begin
        bus.mem_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (clr || !bus.mem_we) begin
                we_cycles = 0;
                bus.mem_ack = ack_noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end else begin
                bus.mem_ack = (we_cycles >= ack_delay);
                we_cycles++;
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Present one command and hold it until accepted, or until the session ends.
    task automatic apply_stimulus(input logic [4:0] sel, input logic [3:0] operand, output bit accepted);
        int  waited = 0;
        bit  stop   = 1'b0;
        accepted = 1'b0;
        @(negedge clk);
        {bus.cmd_lda, bus.cmd_add, bus.cmd_sub, bus.cmd_out, bus.cmd_hlt} = sel;
        bus.cmd_operand = operand;
        bus.cmd_valid = 1'b1;
        while (!stop) begin
            if (bus.cmd_ready) begin
                @(posedge clk);
                #1;
                accepted = 1'b1;
                stop = 1'b1;
            end else if (bus.load_done || bus.load_err) begin
                stop = 1'b1;
            end else if (waited >= 60) begin
                check_output("cmd_accept_timeout", 32'd0, 32'd1);
                stop = 1'b1;
            end else begin
                @(negedge clk);
                waited++;
            end
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic send(input logic [4:0] sel, input logic [3:0] operand);
        bit acc;
        apply_stimulus(sel, operand, acc);
    endtask

    task automatic wait_end();
        int n = 0;
        while (!(bus.load_done || bus.load_err) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check_output("session_end_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [11:0] exp_norm [5];
        int  we_hi;
        int  n_cmds;
        int  r;
        int  bi;
        int  bj;
        bit  acc;
        logic [4:0] sel;

        exp_norm = '{12'h009, 12'h11A, 12'h22B, 12'h3E0, 12'h4F0};
        bus.start = 1'b0;
        bus.cmd_valid = 1'b0;
        {bus.cmd_lda, bus.cmd_add, bus.cmd_sub, bus.cmd_out, bus.cmd_hlt} = 5'b0;
        bus.cmd_operand = 4'h0;

        // Asynchronous reset before any clock edge.
        #2 clr = 1'b1;
        #2;
        check_output("reset_cmd_ready",   32'(bus.cmd_ready),     32'd0);
        check_output("reset_mem_we",      32'(bus.mem_we),        32'd0);
        check_output("reset_low_cpu_clr", 32'(bus.low_cpu_clr),   32'd1);
        check_output("reset_words",       32'(bus.words_written), 32'd0);
        repeat (2) @(negedge clk);
        clr = 1'b0;

        // Normal program.
        write_log.delete();
        pulse_start();
        send(S_LDA, 4'h9); send(S_ADD, 4'hA); send(S_SUB, 4'hB);
        send(S_OUT, 4'h0); send(S_HLT, 4'h0);
        wait_end();
        check_output("norm_log_size", 32'(write_log.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            if (i < write_log.size()) check_output("norm_word", 32'(write_log[i]), 32'(exp_norm[i]));
        check_output("norm_done",    32'(bus.load_done),     32'd1);
        check_output("norm_words",   32'(bus.words_written), 32'd5);
        check_output("norm_cpu_clr", 32'(bus.low_cpu_clr),   32'd1);

        // Slow RAM on the first write.
        write_log.delete();
        ack_delay = 5;
        pulse_start();
        send(S_LDA, 4'h9);
        we_hi = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.mem_we) we_hi++;
            else break;
        end
        check_output("slow_we_cycles", 32'(we_hi), 32'd6);
        ack_delay = 0;
        send(S_HLT, 4'h0);
        wait_end();
        check_output("slow_log_size", 32'(write_log.size()), 32'd2);
        check_output("slow_first",    32'(write_log[0]),      32'h009);

        // Bad command, then recovery with a clean program.
        write_log.delete();
        pulse_start();
        send(S_ADD | S_SUB, 4'h1);
        wait_end();
        check_output("bad_err",      32'(bus.load_err),      32'd1);
        check_output("bad_cpu_clr",  32'(bus.low_cpu_clr),  32'd0);
        check_output("bad_no_write", 32'(write_log.size()), 32'd0);
        pulse_start();
        send(S_LDA, 4'h3); send(S_HLT, 4'h0);
        wait_end();
        check_output("recover_word", 32'(write_log[0]), 32'h003);
        check_output("recover_done", 32'(bus.load_done), 32'd1);

        // Overflow: sixteen ADD 1 with no HLT.
        write_log.delete();
        pulse_start();
        for (int i = 0; i < 16; i++) send(S_ADD, 4'h1);
        wait_end();
        check_output("ovf_err",   32'(bus.load_err),      32'd1);
        check_output("ovf_words", 32'(bus.words_written), 32'd16);
        check_output("ovf_size",  32'(write_log.size()),  32'd16);
        check_output("ovf_last",  32'(write_log[15]),     32'hF11);

        // HLT as the sixteenth word completes normally.
        write_log.delete();
        pulse_start();
        for (int i = 0; i < 15; i++) send(S_ADD, 4'h1);
        send(S_HLT, 4'h0);
        wait_end();
        check_output("full_done",  32'(bus.load_done),     32'd1);
        check_output("full_err",   32'(bus.load_err),      32'd0);
        check_output("full_words", 32'(bus.words_written), 32'd16);
        check_output("full_last",  32'(write_log[15]),     32'hFF0);

        // Reset while a write is pending.
        ack_delay = 10;
        pulse_start();
        send(S_LDA, 4'h5);
        repeat (3) @(negedge clk);
        #2 clr = 1'b1;
        #1;
        check_output("midrst_mem_we",   32'(bus.mem_we),        32'd0);
        check_output("midrst_cpu_clr",  32'(bus.low_cpu_clr),   32'd1);
        check_output("midrst_mem_data", 32'(bus.mem_data),      32'd0);
        check_output("midrst_words",    32'(bus.words_written), 32'd0);
        @(negedge clk);
        clr = 1'b0;
        ack_delay = 0;
        write_log.delete();
        pulse_start();
        send(S_LDA, 4'h1); send(S_HLT, 4'h0);
        wait_end();
        check_output("midrst_restart0", 32'(write_log[0]), 32'h001);
        check_output("midrst_restart1", 32'(write_log[1]), 32'h1F0);

        // Operands of OUT and HLT are dropped.
        write_log.delete();
        pulse_start();
        send(S_OUT, 4'h7); send(S_HLT, 4'h5);
        wait_end();
        check_output("mask_out", 32'(write_log[0]), 32'h0E0);
        check_output("mask_hlt", 32'(write_log[1]), 32'h1F0);

        // Randomized sessions with ack noise and ignored start pulses.
        ack_noise = 1'b1;
        for (int s = 0; s < 25; s++) begin
            ack_delay = $urandom_range(0, 3);
            pulse_start();
            n_cmds = $urandom_range(1, 18);
            acc = 1'b1;
            for (int c = 0; c < n_cmds && acc; c++) begin
                if ($urandom_range(0, 9) == 0) begin
                    @(negedge clk);
                    if (!(bus.load_done || bus.load_err)) begin
                        bus.start = 1'b1;
                        @(negedge clk);
                        bus.start = 1'b0;
                    end
                end
                r = $urandom_range(0, 19);
                if (r == 0) sel = 5'b00000;
                else if (r == 1) begin
                    bi = $urandom_range(0, 4);
                    bj = (bi + $urandom_range(1, 4)) % 5;
                    sel = 5'(1 << bi) | 5'(1 << bj);
                end
                else if (r < 4) sel = S_HLT;
                else sel = 5'(1 << $urandom_range(1, 4));
                apply_stimulus(sel, 4'($urandom_range(0, 15)), acc);
            end
            if (!(bus.load_done || bus.load_err)) send(S_HLT, 4'($urandom_range(0, 15)));
            wait_end();
        end
        ack_noise = 1'b0;

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
